// File: rtl/nids_result_queue.sv
// nids_result_queue: tagged FIFO of classification results, drained over an Avalon-style slave,
// with total/attack/drop counters and a level-threshold interrupt.
module nids_result_queue #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int SEQ_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  res_valid,
    input  logic                  res_attack,
    input  logic [DATA_WIDTH-1:0] res_major,
    input  logic [DATA_WIDTH-1:0] res_minor,
    input  logic [3:0]            avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [31:0]           avs_writedata,
    output logic [31:0]           avs_readdata,
    output logic                  irq
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [SEQ_WIDTH-1:0]  mem_seq_q [DEPTH];
    logic                  mem_att_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_maj_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_min_q [DEPTH];

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]          level_q, level_d;
    logic [SEQ_WIDTH-1:0] seq_q, seq_d;
    logic [31:0]          total_q, total_d, attack_q, attack_d, drop_q, drop_d;
    logic                 ovf_q, ovf_d, irq_en_q, irq_en_d, irq_q, irq_d;
    logic [15:0]          thresh_q, thresh_d;
    logic [31:0]          readdata_q, readdata_d, rd_mux;

    logic ctrl_wr, pop_req, flush, clr, empty, full, pop, push, drop;
    logic [15:0] head_seq;
    logic head_att;
    logic [31:0] head_maj, head_min;
    logic unused_wd;

    assign unused_wd = ^avs_writedata[31:16];

    always_comb begin
        ctrl_wr  = avs_write && avs_address == 4'd8;
        pop_req  = avs_write && avs_address == 4'd4;
        flush    = ctrl_wr & avs_writedata[2];
        clr      = ctrl_wr & avs_writedata[1];
        empty    = level_q == '0;
        full     = level_q == LVL_FULL;
        pop      = pop_req & ~empty & ~flush;
        // flush discards the queue but still accepts a coincident result as the sole entry
        push     = res_valid & (flush | ~full | pop);
        drop     = res_valid & ~push;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + AW'(pop);
        level_d  = flush ? (AW+1)'(res_valid) : level_q + (AW+1)'(push) - (AW+1)'(pop);
        seq_d    = seq_q + SEQ_WIDTH'(res_valid);
        total_d  = clr ? '0 : total_q + 32'(res_valid && total_q != '1);
        attack_d = clr ? '0 : attack_q + 32'(res_valid && res_attack && attack_q != '1);
        drop_d   = clr ? '0 : drop_q + 32'(drop && drop_q != '1);
        ovf_d    = ~clr & (ovf_q | drop);
        irq_en_d = ctrl_wr ? avs_writedata[0] : irq_en_q;
        thresh_d = (avs_write && avs_address == 4'd9) ? avs_writedata[15:0] : thresh_q;
        irq_d    = irq_en_q & (thresh_q != '0) & (16'(level_q) >= thresh_q);
    end

    always_comb begin
        head_seq = empty ? '0 : 16'(mem_seq_q[rd_ptr_q]);
        head_att = ~empty & mem_att_q[rd_ptr_q];
        head_maj = empty ? '0 : 32'(mem_maj_q[rd_ptr_q]);
        head_min = empty ? '0 : 32'(mem_min_q[rd_ptr_q]);
        case (avs_address)
            4'd0:    rd_mux = {13'b0, ovf_q, full, empty, 16'(level_q)};
            4'd1:    rd_mux = {head_seq, 15'b0, head_att};
            4'd2:    rd_mux = head_maj;
            4'd3:    rd_mux = head_min;
            4'd5:    rd_mux = total_q;
            4'd6:    rd_mux = attack_q;
            4'd7:    rd_mux = drop_q;
            4'd8:    rd_mux = {31'b0, irq_en_q};
            4'd9:    rd_mux = {16'b0, thresh_q};
            default: rd_mux = '0;
        endcase
        readdata_d = avs_read ? rd_mux : readdata_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_seq_q[wr_ptr_q] <= seq_q;
            mem_att_q[wr_ptr_q] <= res_attack;
            mem_maj_q[wr_ptr_q] <= res_major;
            mem_min_q[wr_ptr_q] <= res_minor;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            seq_q      <= '0;
            total_q    <= '0;
            attack_q   <= '0;
            drop_q     <= '0;
            ovf_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            thresh_q   <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            seq_q      <= seq_d;
            total_q    <= total_d;
            attack_q   <= attack_d;
            drop_q     <= drop_d;
            ovf_q      <= ovf_d;
            irq_en_q   <= irq_en_d;
            thresh_q   <= thresh_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign avs_readdata = readdata_q;
    assign irq          = irq_q;
endmodule

// File: tb/tb_nids_result_queue.sv
// tb_nids_result_queue: directed, table-driven and randomized checks against a queue-based model.
module tb_nids_result_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        res_valid = 1'b0, res_attack = 1'b0;
    logic [31:0] res_major = '0, res_minor = '0;
    logic [3:0]  avs_address = '0;
    logic        avs_read = 1'b0, avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        irq;

    always #5 clk = ~clk;

    nids_result_queue dut (
        .clk(clk), .rst(rst), .res_valid(res_valid), .res_attack(res_attack),
        .res_major(res_major), .res_minor(res_minor), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata), .irq(irq)
    );

    typedef struct packed {
        logic [15:0] seq;
        logic        att;
        logic [31:0] maj;
        logic [31:0] mn;
    } ent_t;

    typedef struct {
        bit          w;
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;

    int n_chk = 0, n_err = 0;
    ent_t q[$];
    logic [31:0] m_tot, m_att, m_drop, exp_hold;
    logic        m_ovf, m_en;
    logic [15:0] m_th, m_seq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        int n = q.size();
        case (a)
            4'd0: return {13'b0, m_ovf, n == 16, n == 0, 16'(n)};
            4'd1: return (n > 0) ? {q[0].seq, 15'b0, q[0].att} : 32'd0;
            4'd2: return (n > 0) ? q[0].maj : 32'd0;
            4'd3: return (n > 0) ? q[0].mn : 32'd0;
            4'd5: return m_tot;
            4'd6: return m_att;
            4'd7: return m_drop;
            4'd8: return {31'b0, m_en};
            4'd9: return {16'b0, m_th};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        q.delete();
        m_tot = 0; m_att = 0; m_drop = 0; m_ovf = 0; m_en = 0; m_th = 0; m_seq = 0;
        exp_hold = 0;
    endtask

    task automatic m_step(input bit rv, input bit att, input logic [31:0] maj, input logic [31:0] mn,
                          input bit wr, input logic [3:0] a, input logic [31:0] wd);
        bit fl = wr && a == 4'd8 && wd[2];
        bit cl = wr && a == 4'd8 && wd[1];
        bit dropped = 0;
        ent_t e;
        e = '{seq: m_seq, att: att, maj: maj, mn: mn};
        if (fl) begin
            q.delete();
            if (rv) q.push_back(e);
        end else begin
            if (wr && a == 4'd4 && q.size() > 0) void'(q.pop_front());
            if (rv) begin
                if (q.size() < 16) q.push_back(e);
                else dropped = 1;
            end
        end
        if (cl) begin
            m_tot = 0; m_att = 0; m_drop = 0; m_ovf = 0;
        end else begin
            if (rv) m_tot = sat(m_tot);
            if (rv && att) m_att = sat(m_att);
            if (dropped) begin m_drop = sat(m_drop); m_ovf = 1; end
        end
        if (rv) m_seq = m_seq + 16'd1;
        if (wr && a == 4'd8) m_en = wd[0];
        if (wr && a == 4'd9) m_th = wd[15:0];
    endtask

    // One clock of stimulus; readdata and irq are checked against the model every cycle.
    task automatic cyc(input bit rv, input bit att, input logic [31:0] maj, input logic [31:0] mn,
                       input bit rd, input bit wr, input logic [3:0] a, input logic [31:0] wd);
        logic [31:0] exp_rd;
        logic irq_e;
        res_valid = rv; res_attack = att; res_major = maj; res_minor = mn;
        avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = wd;
        exp_rd = rd ? m_read(a) : exp_hold;
        irq_e = m_en && m_th != 0 && q.size() >= int'(m_th);
        m_step(rv, att, maj, mn, wr, a, wd);
        @(posedge clk);
        #1;
        chk("readdata", avs_readdata, exp_rd);
        chk("irq", {31'b0, irq}, {31'b0, irq_e});
        exp_hold = exp_rd;
        res_valid = 0; avs_read = 0; avs_write = 0;
    endtask

    task automatic do_reset();
        rst = 1; res_valid = 0; avs_write = 0; avs_read = 1; avs_address = 4'd0;
        @(posedge clk);
        #1;
        chk("rst_readdata", avs_readdata, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        rst = 0; avs_read = 0;
        m_reset();
    endtask

    task automatic push(input bit att, input logic [31:0] maj, input logic [31:0] mn);
        cyc(1, att, maj, mn, 0, 0, 4'd0, 32'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cyc(0, 0, 0, 0, 0, 1, a, d);
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        cyc(0, 0, 0, 0, 1, 0, a, 32'd0);
        v = avs_readdata;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 4'd0, 32'd0);
    endtask

    vec_t vt[22];
    logic [31:0] v;

    initial begin
        vt[0] = '{1, 4'd0,  32'hFFFF_FFFF, 0};
        vt[1] = '{1, 4'd5,  32'h0000_00FF, 0};
        vt[2] = '{1, 4'd12, 32'h0000_00FF, 0};
        vt[3] = '{1, 4'd15, 32'h0000_00FF, 0};
        vt[4] = '{1, 4'd9,  32'h0001_2345, 0};
        vt[5] = '{1, 4'd8,  32'h0000_0001, 0};
        for (int i = 0; i < 16; i++)
            vt[6+i] = '{0, 4'(i), 0, 32'd0};
        vt[6+0].e = 32'h0001_0000;
        vt[6+8].e = 32'h0000_0001;
        vt[6+9].e = 32'h0000_2345;

        // Register map after reset, with writes to read-only/unmapped offsets ignored
        do_reset();
        for (int i = 0; i < 22; i++) begin
            if (vt[i].w) wr(vt[i].a, vt[i].d);
            else begin
                rd(vt[i].a, v);
                chk($sformatf("tbl_rd%0d", vt[i].a), v, vt[i].e);
            end
        end

        // Basic push/pop and head fields
        do_reset();
        push(1, 5, 50); push(0, 6, 60); push(1, 7, 70);
        rd(4'd0, v); chk("t1_status", v, 32'h0000_0003);
        rd(4'd1, v); chk("t1_tag", v, 32'h0000_0001);
        rd(4'd2, v); chk("t1_major", v, 32'd5);
        rd(4'd3, v); chk("t1_minor", v, 32'd50);
        wr(4'd4, 0);
        rd(4'd2, v); chk("t1_major_pop", v, 32'd6);
        rd(4'd6, v); chk("t1_attack_cnt", v, 32'd2);

        // Overflow and ordered drain
        do_reset();
        for (int i = 0; i < 18; i++) push(i[0], i, i + 100);
        rd(4'd0, v); chk("t2_status", v, 32'h0006_0010);
        rd(4'd7, v); chk("t2_drop", v, 32'd2);
        rd(4'd5, v); chk("t2_total", v, 32'd18);
        for (int i = 0; i < 16; i++) begin
            rd(4'd1, v); chk($sformatf("t2_seq%0d", i), v, {16'(i), 15'b0, i[0]});
            wr(4'd4, 0);
        end
        rd(4'd0, v); chk("t2_status_drained", v, 32'h0005_0000);

        // Full with coincident pop accepts the result
        do_reset();
        for (int i = 0; i < 16; i++) push(0, i, 0);
        cyc(1, 0, 99, 0, 0, 1, 4'd4, 0);
        rd(4'd7, v); chk("t3_drop", v, 32'd0);
        rd(4'd0, v); chk("t3_status", v, 32'h0002_0010);
        for (int i = 0; i < 15; i++) wr(4'd4, 0);
        rd(4'd1, v); chk("t3_tail_tag", v, 32'h0010_0000);
        rd(4'd2, v); chk("t3_tail_major", v, 32'd99);

        // Threshold interrupt with one cycle of lag
        do_reset();
        wr(4'd9, 4); wr(4'd8, 1);
        for (int i = 0; i < 4; i++) push(0, i, 0);
        chk("t4_irq_lag", {31'b0, irq}, 32'd0);
        idle();
        chk("t4_irq_high", {31'b0, irq}, 32'd1);
        wr(4'd4, 0);
        chk("t4_irq_pop_lag", {31'b0, irq}, 32'd1);
        idle();
        chk("t4_irq_low", {31'b0, irq}, 32'd0);

        // Flush + clear with coincident result
        do_reset();
        for (int i = 0; i < 17; i++) push(1, i, 0);
        cyc(1, 1, 3, 4, 0, 1, 4'd8, 32'h6);
        rd(4'd0, v); chk("t5_status", v, 32'h0000_0001);
        rd(4'd5, v); chk("t5_total", v, 32'd0);
        rd(4'd6, v); chk("t5_attack", v, 32'd0);
        rd(4'd7, v); chk("t5_drop", v, 32'd0);
        rd(4'd8, v); chk("t5_ctrl", v, 32'd0);
        rd(4'd2, v); chk("t5_major", v, 32'd3);

        // Pop on empty, then sequence wrap
        do_reset();
        wr(4'd4, 0);
        rd(4'd0, v); chk("t6_status", v, 32'h0001_0000);
        rd(4'd1, v); chk("t6_tag", v, 32'd0);
        rd(4'd2, v); chk("t6_major", v, 32'd0);
        rd(4'd3, v); chk("t6_minor", v, 32'd0);
        for (int i = 0; i < 65536; i++) push(0, i, 0);
        cyc(1, 1, 7, 8, 0, 1, 4'd8, 32'h4);
        rd(4'd1, v); chk("t6_wrap_tag", v, 32'h0000_0001);
        rd(4'd2, v); chk("t6_wrap_major", v, 32'd7);
        rd(4'd5, v); chk("t6_total", v, 32'd65537);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit rv, att, rdn, wrn;
            logic [3:0] a;
            logic [31:0] wd;
            int k;
            rv  = $urandom_range(0, 99) < ((i < 1500) ? 60 : 15);
            att = 1'($urandom_range(0, 1));
            rdn = 1'($urandom_range(0, 1));
            wrn = $urandom_range(0, 99) < 45;
            a   = 4'($urandom_range(0, 15));
            wd  = $urandom;
            if (wrn) begin
                k = $urandom_range(0, 19);
                if (k < 12) a = 4'd4;
                else if (k < 14) begin a = 4'd9; wd = 32'($urandom_range(0, 17)); end
                else if (k < 16) begin a = 4'd8; wd = 32'($urandom_range(0, 1)); end
                else if (k == 16) begin a = 4'd8; wd = 32'($urandom_range(0, 7)); end
            end
            cyc(rv, att, $urandom, $urandom, rdn, wrn, a, wd);
        end
        do_reset();
        rd(4'd0, v); chk("final_status", v, 32'h0001_0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
